cd: RTL and testbench



---
 rtl/cd_pkg.sv | 23 ++
 rtl/cd_toggle_div.sv | 33 +++
 rtl/cd.sv | 81 ++++++++
 tb/tb_cd.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_pkg.sv
// Shared constants for the peripheral clock divider: config addresses,
// base half-periods and counter widths.
package cd_pkg;

    localparam logic [3:0] CD_ADDR_UART = 4'h4;
    localparam logic [3:0] CD_ADDR_LM   = 4'h8;

    localparam int unsigned UART_BASE = 16;
    localparam int unsigned LM_BASE   = 4;

    // Counter widths hold HALF-1 at the slowest selectable rate.
    localparam int unsigned UART_CW = 11;
    localparam int unsigned LM_CW   = 5;

    function automatic logic [UART_CW:0] uart_half(input logic [2:0] sel);
        return (UART_CW + 1)'(UART_BASE) << sel;
    endfunction

    function automatic logic [LM_CW:0] lm_half(input logic [1:0] sel);
        return (LM_CW + 1)'(LM_BASE) << sel;
    endfunction

endpackage

// File: rtl/cd_toggle_div.sv
// Toggle divider: flips q every `half` cycles; restart clears the count
// while holding the output level.
module cd_toggle_div #(
    parameter int unsigned CW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [CW:0] half,
    input  logic        restart,
    output logic        q
);

    logic [CW-1:0] count;
    logic          at_term;

    assign at_term = ({1'b0, count} == (half - (CW + 1)'(1)));

    // restart has priority, so a rate change on a terminal-count edge does not toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            q     <= 1'b0;
        end else if (restart) begin
            count <= '0;
        end else if (at_term) begin
            count <= '0;
            q     <= ~q;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cd.sv
// Peripheral clock divider: configurable UART/LM clocks, fixed debounce
// clock and a registered copy of the external VGA pixel clock.
module cd
    import cd_pkg::*;
#(
    parameter int unsigned DB_HALF = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clkinVGA,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic       clk_VGA,
    output logic       clk_UART,
    output logic       clk_LM,
    output logic       clk_DB
);

    localparam int unsigned DB_CW = (DB_HALF > 1) ? $clog2(DB_HALF) : 1;

    logic       rst;
    logic       wr;
    logic       uart_chg;
    logic       lm_chg;
    logic [2:0] uart_sel;
    logic [1:0] lm_sel;
    logic       unused_data;

    // rst_n is active-high; the name is kept for compatibility.
    assign rst         = rst_n;
    assign unused_data = ^c_data[7:3];

    assign wr       = c_valid && c_ready;
    assign uart_chg = wr && (c_addr == CD_ADDR_UART) && (c_data[2:0] != uart_sel);
    assign lm_chg   = wr && (c_addr == CD_ADDR_LM) && (c_data[1:0] != lm_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_ready  <= 1'b0;
            uart_sel <= '0;
            lm_sel   <= '0;
            clk_VGA  <= 1'b0;
        end else begin
            c_ready <= 1'b1;
            clk_VGA <= clkinVGA;
            if (wr && (c_addr == CD_ADDR_UART)) begin
                uart_sel <= c_data[2:0];
            end
            if (wr && (c_addr == CD_ADDR_LM)) begin
                lm_sel <= c_data[1:0];
            end
        end
    end

    cd_toggle_div #(.CW(UART_CW)) u_uart_div (
        .clk     (clk),
        .rst     (rst),
        .half    (uart_half(uart_sel)),
        .restart (uart_chg),
        .q       (clk_UART)
    );

    cd_toggle_div #(.CW(LM_CW)) u_lm_div (
        .clk     (clk),
        .rst     (rst),
        .half    (lm_half(lm_sel)),
        .restart (lm_chg),
        .q       (clk_LM)
    );

    cd_toggle_div #(.CW(DB_CW)) u_db_div (
        .clk     (clk),
        .rst     (rst),
        .half    ((DB_CW + 1)'(DB_HALF)),
        .restart (1'b0),
        .q       (clk_DB)
    );

endmodule

// File: tb/tb_cd.sv
// Self-checking bench for cd: every output is compared each cycle against
// a model that derives levels from cycles elapsed since the last anchor.
module tb_cd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clkinVGA;
    logic       c_valid;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       c_ready;
    logic       clk_VGA;
    logic       clk_UART;
    logic       clk_LM;
    logic       clk_DB;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cd #(.DB_HALF(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clkinVGA (clkinVGA),
        .c_valid  (c_valid),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_ready  (c_ready),
        .clk_VGA  (clk_VGA),
        .clk_UART (clk_UART),
        .clk_LM   (clk_LM),
        .clk_DB   (clk_DB)
    );

    // Model: level = anchor level xor parity of (cycles since anchor / half).
    int u_sel_m, l_sel_m;
    int u_n, l_n, d_n;
    bit u_a, l_a, d_a;
    bit rdy_m, vga_m;

    function automatic bit lvl(bit a, int n, int half);
        return a ^ bit'((n / half) % 2);
    endfunction

    function automatic bit exp_u();
        return lvl(u_a, u_n, 16 << u_sel_m);
    endfunction

    function automatic bit exp_l();
        return lvl(l_a, l_n, 4 << l_sel_m);
    endfunction

    function automatic bit exp_d();
        return lvl(d_a, d_n, 1024);
    endfunction

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            u_sel_m = 0; l_sel_m = 0;
            u_n = 0; l_n = 0; d_n = 0;
            u_a = 0; l_a = 0; d_a = 0;
            rdy_m = 0; vga_m = 0;
        end else begin
            if (c_valid && rdy_m && c_addr == 4'h4 && int'(c_data[2:0]) != u_sel_m) begin
                u_a = exp_u();
                u_n = 0;
                u_sel_m = int'(c_data[2:0]);
            end else begin
                u_n++;
            end
            if (c_valid && rdy_m && c_addr == 4'h8 && int'(c_data[1:0]) != l_sel_m) begin
                l_a = exp_l();
                l_n = 0;
                l_sel_m = int'(c_data[1:0]);
            end else begin
                l_n++;
            end
            d_n++;
            rdy_m = 1;
            vga_m = clkinVGA;
        end
    end

    task automatic test_reset();
        rst_n = 1'b1; c_valid = 1'b0; c_addr = '0; c_data = '0; clkinVGA = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({c_ready, clk_VGA, clk_UART, clk_LM, clk_DB} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs got=%b want=00000", {c_ready, clk_VGA, clk_UART, clk_LM, clk_DB});
            end
        end
        rst_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (c_ready !== 1'b1) begin
                errors++; $display("FAIL reset_ready cyc=%0d got=%b want=1", i, c_ready);
            end
            checks++;
            if (clk_UART !== exp_u()) begin
                errors++; $display("FAIL reset_uart cyc=%0d got=%b want=%b", i, clk_UART, exp_u());
            end
            checks++;
            if (clk_LM !== exp_l()) begin
                errors++; $display("FAIL reset_lm cyc=%0d got=%b want=%b", i, clk_LM, exp_l());
            end
        end
    endtask

    task automatic test_uart_write();
        c_valid = 1'b1; c_addr = 4'h4;
        c_data = {5'($urandom), 3'b100};
        for (int i = 0; i < 600; i++) begin
            if (i == 78) c_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (clk_UART !== exp_u()) begin
                errors++; $display("FAIL uart_write cyc=%0d got=%b want=%b", i, clk_UART, exp_u());
            end
        end
    endtask

    task automatic test_rate_change();
        c_valid = 1'b1; c_addr = 4'h4; c_data = {5'($urandom), 3'b010};
        @(negedge clk);
        c_addr = 4'h8; c_data = {6'($urandom), 2'b10};
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            c_valid = 1'b0;
            checks++;
            if (clk_UART !== exp_u()) begin
                errors++; $display("FAIL change_uart cyc=%0d got=%b want=%b", i, clk_UART, exp_u());
            end
            checks++;
            if (clk_LM !== exp_l()) begin
                errors++; $display("FAIL change_lm cyc=%0d got=%b want=%b", i, clk_LM, exp_l());
            end
        end
    endtask

    task automatic test_restore();
        c_valid = 1'b1; c_addr = 4'h4; c_data = 8'h00;
        @(negedge clk);
        c_addr = 4'h8;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            c_valid = 1'b0;
            checks++;
            if (clk_UART !== exp_u()) begin
                errors++; $display("FAIL restore_uart cyc=%0d got=%b want=%b", i, clk_UART, exp_u());
            end
            checks++;
            if (clk_LM !== exp_l()) begin
                errors++; $display("FAIL restore_lm cyc=%0d got=%b want=%b", i, clk_LM, exp_l());
            end
        end
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 120; i++) begin
            c_valid = (i < 20);
            c_addr  = (i == 0) ? 4'h3 : 4'($urandom);
            if (c_addr == 4'h4 || c_addr == 4'h8) c_addr = 4'h3;
            c_data  = 8'hFF;
            @(negedge clk);
            checks++;
            if ({clk_UART, clk_LM, clk_DB} !== {exp_u(), exp_l(), exp_d()}) begin
                errors++;
                $display("FAIL ignored_addr cyc=%0d got=%b want=%b", i,
                         {clk_UART, clk_LM, clk_DB}, {exp_u(), exp_l(), exp_d()});
            end
        end
        c_valid = 1'b0;
    endtask

    task automatic test_vga();
        for (int i = 0; i < 400; i++) begin
            if (i % 78 == 0) clkinVGA = ~clkinVGA;
            @(negedge clk);
            checks++;
            if (clk_VGA !== vga_m) begin
                errors++; $display("FAIL vga_follow cyc=%0d got=%b want=%b", i, clk_VGA, vga_m);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if ({c_ready, clk_VGA, clk_UART, clk_LM, clk_DB} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got=%b want=00000", {c_ready, clk_VGA, clk_UART, clk_LM, clk_DB});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if ({c_ready, clk_UART, clk_LM} !== {1'b1, exp_u(), exp_l()}) begin
                errors++;
                $display("FAIL async_recover cyc=%0d got=%b want=%b", i,
                         {c_ready, clk_UART, clk_LM}, {1'b1, exp_u(), exp_l()});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5000; i++) begin
            c_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       c_addr = 4'h4;
                1:       c_addr = 4'h8;
                default: c_addr = 4'($urandom);
            endcase
            c_data = 8'($urandom);
            if ($urandom_range(0, 30) == 0) clkinVGA = ~clkinVGA;
            @(negedge clk);
            checks++;
            if ({c_ready, clk_VGA, clk_UART, clk_LM, clk_DB} !== {1'b1, vga_m, exp_u(), exp_l(), exp_d()}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b want=%b", i,
                         {c_ready, clk_VGA, clk_UART, clk_LM, clk_DB},
                         {1'b1, vga_m, exp_u(), exp_l(), exp_d()});
            end
        end
        c_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_uart_write();
        test_rate_change();
        test_restore();
        test_ignored();
        test_vga();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
